// File: rtl/rx_frame_check_if.sv
`default_nettype none
// rx_frame_check_if -- RECV bit stream in, per-frame status out.  Rev 1.0
interface rx_frame_check_if;
  logic        di_signal;
  logic        di_signal_vld;
  logic        di_payload;
  logic        di_payload_vld;
  logic        frame_done;
  logic        sig_err;
  logic        abort;
  logic [3:0]  frame_rate;
  logic [11:0] frame_len;
  logic [15:0] bit_cnt;
  logic [15:0] err_cnt;
  logic [15:0] frame_cnt;

  modport master (
    output di_signal, di_signal_vld, di_payload, di_payload_vld,
    input  frame_done, sig_err, abort, frame_rate, frame_len,
           bit_cnt, err_cnt, frame_cnt
  );

  modport slave (
    input  di_signal, di_signal_vld, di_payload, di_payload_vld,
    output frame_done, sig_err, abort, frame_rate, frame_len,
           bit_cnt, err_cnt, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_check.sv
`default_nettype none
// rx_frame_check -- decodes the 24-bit SIGNAL field and checks the PRBS payload.
// Rev 1.0
module rx_frame_check #(
  parameter logic [15:0] TIMEOUT   = 16'd65535,
  parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
  input  wire logic       clk,
  input  wire logic       rst,
  rx_frame_check_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SIG  = 2'd1,
    S_PLD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [22:0] r_sr;
  logic [4:0]  r_sig_n;
  logic [6:0]  r_lfsr;
  logic [15:0] r_idle;
  logic        r_pend_err;
  logic        r_pend_abort;
  logic        r_done;
  logic        r_sig_err;
  logic        r_abort;
  logic [3:0]  r_rate;
  logic [11:0] r_len;
  logic [15:0] r_bits;
  logic [15:0] r_errs;
  logic [15:0] r_frames;

  logic [23:0] w_word;
  logic        w_rate_ok;
  logic        w_word_ok;
  logic        w_in_frame;
  logic        w_pld_take;
  logic        w_accept;
  logic        w_last_sig;
  logic        w_last_pld;
  logic        w_timeout;
  logic        w_exp;
  logic [15:0] w_bits_inc;

  // The 24th bit is evaluated combinationally so a bad SIGNAL closes as fast as a payload end.
  assign w_word     = {bus.di_signal, r_sr};
  assign w_in_frame = (r_state == S_SIG) || (r_state == S_PLD);
  assign w_pld_take = (r_state == S_PLD) && bus.di_payload_vld && !bus.di_signal_vld;
  assign w_accept   = bus.di_signal_vld || w_pld_take;
  assign w_last_sig = (r_state == S_SIG) && bus.di_signal_vld && (r_sig_n == 5'd23);
  assign w_exp      = r_lfsr[6] ^ r_lfsr[3];
  assign w_bits_inc = (r_bits == 16'hFFFF) ? r_bits : r_bits + 16'd1;
  assign w_last_pld = w_pld_take && (w_bits_inc == {1'b0, r_len, 3'b000});
  assign w_timeout  = w_in_frame && !w_accept && (r_idle == TIMEOUT - 16'd1);

  always_comb begin
    w_rate_ok = 1'b0;
    case (w_word[3:0])
      4'b1101, 4'b1111, 4'b0101, 4'b0111,
      4'b1001, 4'b1011, 4'b0001, 4'b0011: w_rate_ok = 1'b1;
      default:                           w_rate_ok = 1'b0;
    endcase
  end

  assign w_word_ok = w_rate_ok && !(^w_word[17:0]) && !w_word[4] &&
                     (w_word[23:18] == 6'd0) && (w_word[16:5] != 12'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = bus.di_signal_vld ? S_SIG : S_IDLE;
      S_SIG: begin
        if (w_last_sig)     w_next = w_word_ok ? S_PLD : S_DONE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_PLD: begin
        if (bus.di_signal_vld)           w_next = S_SIG;
        else if (w_last_pld || w_timeout) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr         <= 23'd0;
      r_sig_n      <= 5'd0;
      r_lfsr       <= 7'd0;
      r_idle       <= 16'd0;
      r_pend_err   <= 1'b0;
      r_pend_abort <= 1'b0;
      r_done       <= 1'b0;
      r_sig_err    <= 1'b0;
      r_abort      <= 1'b0;
      r_rate       <= 4'd0;
      r_len        <= 12'd0;
      r_bits       <= 16'd0;
      r_errs       <= 16'd0;
      r_frames     <= 16'd0;
    end else begin
      r_done <= 1'b0;

      if (bus.di_signal_vld) begin
        if (r_state == S_SIG) begin
          r_sr    <= w_word[23:1];
          r_sig_n <= r_sig_n + 5'd1;
        end else begin
          r_sr    <= {bus.di_signal, 22'd0};
          r_sig_n <= 5'd1;
        end
      end

      if (w_last_sig) begin
        r_rate <= w_word[3:0];
        r_len  <= w_word[16:5];
        r_bits <= 16'd0;
        r_errs <= 16'd0;
        r_lfsr <= PRBS_SEED;
      end

      if (w_pld_take) begin
        r_lfsr <= {r_lfsr[5:0], w_exp};
        r_bits <= w_bits_inc;
        if ((bus.di_payload != w_exp) && (r_errs != 16'hFFFF))
          r_errs <= r_errs + 16'd1;
      end

      if ((w_next == S_DONE) && (r_state != S_DONE)) begin
        r_pend_err   <= w_last_sig && !w_word_ok;
        r_pend_abort <= w_timeout;
      end

      // A SIGNAL bit during payload closes the frame here, bypassing DONE.
      if (r_state == S_DONE) begin
        r_done    <= 1'b1;
        r_frames  <= r_frames + 16'd1;
        r_sig_err <= r_pend_err;
        r_abort   <= r_pend_abort;
      end else if ((r_state == S_PLD) && bus.di_signal_vld) begin
        r_done    <= 1'b1;
        r_frames  <= r_frames + 16'd1;
        r_sig_err <= 1'b0;
        r_abort   <= 1'b1;
      end

      if (!w_in_frame || w_accept) r_idle <= 16'd0;
      else                         r_idle <= r_idle + 16'd1;
    end
  end

  assign bus.frame_done = r_done;
  assign bus.sig_err    = r_sig_err;
  assign bus.abort      = r_abort;
  assign bus.frame_rate = r_rate;
  assign bus.frame_len  = r_len;
  assign bus.bit_cnt    = r_bits;
  assign bus.err_cnt    = r_errs;
  assign bus.frame_cnt  = r_frames;

endmodule
`default_nettype wire
